dequant_dezigzag: RTL and testbench

- Sits directly downstream of the coefficient block buffer in the JPEG decode path.
- Accepts a completed 64-coefficient block, given in zigzag order with a differential DC value.
- Reconstructs DC from a per-component predictor, multiplies every coefficient by its quantization table entry, reorders to natural (row-major) order and presents the block to the IDCT.
- Processes LANES coefficients per cycle through a small FSM with a ready/valid output handshake.

---
 rtl/dequant_dezigzag.sv | 160 ++++++++++++++++
 tb/tb_dequant_dezigzag.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequant_dezigzag.sv
// dequant_dezigzag
//   Takes a complete 64-coefficient block in zigzag order (element 0 holds
//   the DC difference), rebuilds the absolute DC from a per-component
//   predictor, multiplies every coefficient by its quantization entry with
//   saturation, and scatters the results into natural (row-major) order for
//   the IDCT. LANES coefficients are processed per cycle.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   data_in       zigzag-ordered signed 12-bit coefficients, [0] = DC diff
//   valid_in      one-cycle pulse: data_in holds a complete block
//   comp_id       component of the incoming block (3 treated as 2)
//   qt_sel        quant table used by the incoming block
//   restart       clears all DC predictors (RSTn marker)
//   in_ready      high when a block can be captured
//   qt_wr_*       quant table write port (zigzag / DQT order)
//   data_out      dequantized block, natural order
//   valid_out     data_out is valid
//   ready_in      downstream accepts data_out
//   overflow      sticky: a block arrived while in_ready was low
module dequant_dezigzag #(
  parameter int BLOCK_SIZE = 64,
  parameter int LANES      = 8,
  parameter int OUT_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BLOCK_SIZE-1:0][11:0]        data_in,
  input  logic                               valid_in,
  input  logic [1:0]                         comp_id,
  input  logic [1:0]                         qt_sel,
  input  logic                               restart,
  output logic                               in_ready,
  input  logic                               qt_wr_en,
  input  logic [1:0]                         qt_wr_sel,
  input  logic [5:0]                         qt_wr_addr,
  input  logic [7:0]                         qt_wr_data,
  output logic [BLOCK_SIZE-1:0][OUT_W-1:0]   data_out,
  output logic                               valid_out,
  input  logic                               ready_in,
  output logic                               overflow
);

  localparam int GROUPS = BLOCK_SIZE / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DEQ  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [20:0] SAT_MAX = 21'(SAT_MAX_I);
  localparam logic signed [20:0] SAT_MIN = 21'(-SAT_MAX_I - 1);

  // zigzag position -> natural (row-major) position
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [1:0]                  state;
  logic [GW-1:0]               grp;
  logic [BLOCK_SIZE-1:0][11:0] coef;
  // Snapshot of the selected table row taken at capture, so a table write
  // in the capture cycle cannot leak into the block already accepted.
  logic [BLOCK_SIZE-1:0][7:0]  qrow;
  logic [7:0]                  qt [4][BLOCK_SIZE];
  logic [11:0]                 pred [0:2];

  logic [1:0]  comp_eff;
  logic [11:0] dc;
  logic        capture;

  logic [5:0]              lane_k    [LANES];
  logic [5:0]              lane_dst  [LANES];
  logic signed [20:0]      lane_prod [LANES];
  logic [OUT_W-1:0]        lane_val  [LANES];

  assign in_ready  = (state == IDLE);
  assign valid_out = (state == OUT);
  assign capture   = valid_in && (state == IDLE);
  assign comp_eff  = (comp_id == 2'd3) ? 2'd2 : comp_id;
  // A coinciding restart clears the predictor before this block uses it.
  assign dc        = (restart ? 12'd0 : pred[comp_eff]) + data_in[0];

  // Per-lane multiply, saturate and destination lookup for the current group
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_k[l]    = 6'(int'(grp) * LANES + l);
      lane_dst[l]  = 6'(ZZ[lane_k[l]]);
      lane_prod[l] = 21'($signed(coef[lane_k[l]])) * $signed(21'({1'b0, qrow[lane_k[l]]}));
      if (lane_prod[l] > SAT_MAX)
        lane_val[l] = SAT_MAX[OUT_W-1:0];
      else if (lane_prod[l] < SAT_MIN)
        lane_val[l] = SAT_MIN[OUT_W-1:0];
      else
        lane_val[l] = lane_prod[l][OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grp      <= '0;
      data_out <= '0;
      overflow <= 1'b0;
      coef     <= '0;
      qrow     <= '0;
      for (int c = 0; c < 3; c++)
        pred[c] <= 12'd0;
      for (int t = 0; t < 4; t++)
        for (int i = 0; i < BLOCK_SIZE; i++)
          qt[t][i] <= 8'd1;
    end else begin
      if (valid_in && (state != IDLE))
        overflow <= 1'b1;

      if (restart)
        for (int c = 0; c < 3; c++)
          pred[c] <= 12'd0;

      case (state)
        IDLE: begin
          if (qt_wr_en)
            qt[qt_wr_sel][qt_wr_addr] <= qt_wr_data;
          if (capture) begin
            coef    <= data_in;
            coef[0] <= dc;
            for (int i = 0; i < BLOCK_SIZE; i++)
              qrow[i] <= qt[qt_sel][i];
            // Later than the restart clear above, so this DC survives it
            pred[comp_eff] <= dc;
            grp   <= '0;
            state <= DEQ;
          end
        end
        DEQ: begin
          for (int l = 0; l < LANES; l++)
            data_out[lane_dst[l]] <= lane_val[l];
          if (grp == GW'(GROUPS - 1))
            state <= OUT;
          else
            grp <= grp + 1'b1;
        end
        OUT: begin
          if (ready_in)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dequant_dezigzag.sv
// tb_dequant_dezigzag
//   Directed bench for dequant_dezigzag. A block-level model predicts each
//   output block from DC prediction, table lookup, saturation and a zigzag
//   order generated by walking anti-diagonals; a compare process checks the
//   handshake signals and the presented block every cycle, and the directed
//   sequences add literal expectations for key coefficients.
module tb_dequant_dezigzag;

  logic                clk = 1'b0;
  logic                rst;
  logic [63:0][11:0]   data_in;
  logic                valid_in;
  logic [1:0]          comp_id;
  logic [1:0]          qt_sel;
  logic                restart;
  logic                in_ready;
  logic                qt_wr_en;
  logic [1:0]          qt_wr_sel;
  logic [5:0]          qt_wr_addr;
  logic [7:0]          qt_wr_data;
  logic [63:0][15:0]   data_out;
  logic                valid_out;
  logic                ready_in;
  logic                overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dequant_dezigzag #(.BLOCK_SIZE(64), .LANES(8), .OUT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .comp_id    (comp_id),
    .qt_sel     (qt_sel),
    .restart    (restart),
    .in_ready   (in_ready),
    .qt_wr_en   (qt_wr_en),
    .qt_wr_sel  (qt_wr_sel),
    .qt_wr_addr (qt_wr_addr),
    .qt_wr_data (qt_wr_data),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .overflow   (overflow)
  );

  // zigzag index -> natural index, built by walking anti-diagonals
  int zz [64];
  initial begin
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz[n] = r * 8 + (s - r);
          n++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz[n] = r * 8 + (s - r);
          n++;
        end
      end
    end
  end

  function automatic int wrap12(input int x);
    logic signed [11:0] t;
    t = 12'(x);
    return int'(t);
  endfunction

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Block-level model: phase 0 idle, 1 dequantizing, 2 presenting
  bit m_init = 1'b0;
  int m_phase, m_cnt;
  bit m_valid, m_ovf;
  int m_pred [3];
  int m_qt   [4][64];
  int m_pend [64];
  int m_out  [64];
  int mp, mdc, mc, ce, bad;

  always @(negedge clk) begin
    if (m_init) begin
      check_output("in_ready", int'(in_ready), int'(m_phase == 0));
      check_output("valid_out", int'(valid_out), int'(m_valid));
      check_output("overflow", int'(overflow), int'(m_ovf));
      if (m_valid) begin
        bad = -1;
        for (int j = 0; j < 64; j++)
          if (bad < 0 && int'($signed(data_out[j])) != m_out[j]) bad = j;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("[TB] FAIL block data_out[%0d]: got %0d expected %0d",
                   bad, $signed(data_out[bad]), m_out[bad]);
        end
      end
    end
    // advance the model across the coming edge
    if (rst) begin
      m_init = 1'b1; m_phase = 0; m_cnt = 0; m_valid = 0; m_ovf = 0;
      for (int c = 0; c < 3; c++) m_pred[c] = 0;
      for (int t = 0; t < 4; t++) for (int i = 0; i < 64; i++) m_qt[t][i] = 1;
    end else if (m_init) begin
      if (valid_in && m_phase != 0) m_ovf = 1;
      ce = (comp_id == 2'd3) ? 2 : int'(comp_id);
      mdc = 0;
      if (m_phase == 0 && valid_in) begin
        mp  = restart ? 0 : m_pred[ce];
        mdc = wrap12(mp + int'($signed(data_in[0])));
        for (int i = 0; i < 64; i++) begin
          mc = (i == 0) ? mdc : int'($signed(data_in[i]));
          m_pend[zz[i]] = sat16(mc * m_qt[qt_sel][i]);
        end
      end
      if (restart) for (int c = 0; c < 3; c++) m_pred[c] = 0;
      case (m_phase)
        0: begin
          if (valid_in) begin
            m_pred[ce] = mdc;
            m_phase = 1;
            m_cnt = 8;
          end
          if (qt_wr_en) m_qt[qt_wr_sel][qt_wr_addr] = int'(qt_wr_data);
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase = 2; m_valid = 1;
            for (int i = 0; i < 64; i++) m_out[i] = m_pend[i];
          end
        end
        default: begin
          if (ready_in) begin m_phase = 0; m_valid = 0; end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int comp, input int sel, input logic rs);
    valid_in = 1'b1;
    comp_id  = 2'(comp);
    qt_sel   = 2'(sel);
    restart  = rs;
    tick();
    valid_in = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!valid_out && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (!valid_out) begin
      errors++;
      $display("[TB] FAIL wait_valid: got timeout expected valid_out within 40 cycles");
    end
  endtask

  task automatic run_dc(input int diff, input int comp, input logic rs, input int exp_dc);
    int c;
    data_in    = '0;
    data_in[0] = 12'(diff);
    apply_stimulus(comp, 0, rs);
    wait_valid(c);
    check_output("dc value", int'($signed(data_out[0])), exp_dc);
    tick();
  endtask

  initial begin
    int c;
    int nz;
    rst = 1'b1; data_in = '0; valid_in = 0; comp_id = 0; qt_sel = 0; restart = 0;
    qt_wr_en = 0; qt_wr_sel = 0; qt_wr_addr = 0; qt_wr_data = 0; ready_in = 1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check_output("reset valid_out", int'(valid_out), 0);
    check_output("reset in_ready", int'(in_ready), 1);
    check_output("reset overflow", int'(overflow), 0);
    nz = 0;
    for (int j = 0; j < 64; j++) if (data_out[j] != 16'd0) nz++;
    check_output("reset data_out nonzero", nz, 0);

    // pass-through reorder and latency
    for (int k = 0; k < 64; k++) data_in[k] = 12'(k);
    data_in[0] = 12'd5;
    apply_stimulus(0, 0, 1'b0);
    wait_valid(c);
    check_output("latency", c, 9);
    check_output("reorder out0", int'($signed(data_out[0])), 5);
    check_output("reorder out1", int'($signed(data_out[1])), 1);
    check_output("reorder out8", int'($signed(data_out[8])), 2);
    check_output("reorder out16", int'($signed(data_out[16])), 3);
    check_output("reorder out2", int'($signed(data_out[2])), 5);
    tick();

    // DC prediction per component and restart
    rst = 1'b1; tick(); rst = 1'b0;
    run_dc(5, 0, 1'b0, 5);
    run_dc(-3, 0, 1'b0, 2);
    run_dc(7, 1, 1'b0, 7);
    run_dc(4, 0, 1'b1, 4);

    // table load and saturation
    for (int a = 0; a < 64; a++) begin
      qt_wr_en = 1; qt_wr_sel = 2'd1; qt_wr_addr = 6'(a); qt_wr_data = 8'd16;
      tick();
    end
    qt_wr_addr = 6'd1; qt_wr_data = 8'd255;
    tick();
    qt_wr_en = 0;
    data_in = '0; data_in[1] = 12'd200; data_in[2] = 12'h800;
    apply_stimulus(2, 1, 1'b0);
    wait_valid(c);
    check_output("sat positive", int'($signed(data_out[1])), 32767);
    check_output("sat negative", int'($signed(data_out[8])), -32768);
    tick();

    // output hold with back-pressure, dropped block sets overflow
    ready_in = 0;
    data_in = '0; data_in[0] = 12'd1; data_in[3] = 12'd9;
    apply_stimulus(0, 0, 1'b0);
    wait_valid(c);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        data_in[0] = 12'd100;
        apply_stimulus(0, 0, 1'b0);
      end else begin
        tick();
      end
    end
    check_output("hold dc", int'($signed(data_out[0])), 5);
    check_output("hold out16", int'($signed(data_out[16])), 9);
    check_output("hold in_ready", int'(in_ready), 0);
    check_output("overflow set", int'(overflow), 1);
    ready_in = 1;
    tick();
    check_output("release in_ready", int'(in_ready), 1);
    check_output("release valid_out", int'(valid_out), 0);

    // table write during DEQ is ignored
    data_in = '0; data_in[5] = 12'd3;
    apply_stimulus(0, 0, 1'b0);
    qt_wr_en = 1; qt_wr_sel = 2'd0; qt_wr_addr = 6'd5; qt_wr_data = 8'd99;
    tick();
    qt_wr_en = 0;
    wait_valid(c);
    check_output("no pred change", int'($signed(data_out[0])), 5);
    tick();
    apply_stimulus(0, 0, 1'b0);
    wait_valid(c);
    check_output("deq write ignored", int'($signed(data_out[2])), 3);
    tick();

    // table write in the capture cycle applies to the following block only
    data_in = '0; data_in[3] = 12'd7;
    qt_wr_en = 1; qt_wr_sel = 2'd0; qt_wr_addr = 6'd3; qt_wr_data = 8'd10;
    apply_stimulus(0, 0, 1'b0);
    qt_wr_en = 0;
    wait_valid(c);
    check_output("capture write old", int'($signed(data_out[16])), 7);
    tick();
    apply_stimulus(0, 0, 1'b0);
    wait_valid(c);
    check_output("capture write new", int'($signed(data_out[16])), 70);
    tick();

    // reset in the third DEQ cycle
    data_in = '0; data_in[0] = 12'd3;
    apply_stimulus(1, 0, 1'b0);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_output("midrst valid_out", int'(valid_out), 0);
    check_output("midrst in_ready", int'(in_ready), 1);
    check_output("midrst overflow", int'(overflow), 0);
    data_in = '0; data_in[0] = 12'd6; data_in[2] = 12'd1;
    apply_stimulus(0, 1, 1'b0);
    wait_valid(c);
    check_output("midrst pred", int'($signed(data_out[0])), 6);
    check_output("midrst table", int'($signed(data_out[8])), 1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
